// File: rtl/bf16_stream_argmin.sv
// Streaming argmin over fixed-length vectors of bfloat16 elements.
// Accepts N_ELEM beats, then holds {minimum, index} until the consumer takes it.
module bf16_stream_argmin #(
  parameter int N_ELEM = 10,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_min,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_next;
  logic [15:0]      r_min;
  logic [15:0]      w_min_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  logic             w_accept;
  logic             w_in_nan;
  logic             w_min_nan;
  logic             w_both_zero;
  logic [15:0]      w_in_key;
  logic [15:0]      w_min_key;
  logic             w_less;

  // Map sign-magnitude onto an unsigned key: positives above negatives,
  // and negatives ordered by inverted magnitude.
  function automatic logic [15:0] order_key(input logic [15:0] v);
    order_key = v[15] ? {1'b0, ~v[14:0]} : {1'b1, v[14:0]};
  endfunction

  assign w_in_nan    = (in_data[14:7] == 8'hFF) && (in_data[6:0] != 7'd0);
  assign w_min_nan   = (r_min[14:7] == 8'hFF) && (r_min[6:0] != 7'd0);
  assign w_both_zero = (in_data[14:0] == 15'd0) && (r_min[14:0] == 15'd0);
  assign w_in_key    = order_key(in_data);
  assign w_min_key   = order_key(r_min);

  // Strictly-less only: ties, +0/-0 and NaN beats never displace the current minimum.
  assign w_less = !w_in_nan && (w_min_nan || (!w_both_zero && (w_in_key < w_min_key)));

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign out_min   = r_min;
  assign out_idx   = r_idx;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_min_next   = r_min;
    w_idx_next   = r_idx;
    if (clear) begin
      w_state_next = ACCUM;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if ((r_cnt == '0) || w_less) begin
              w_min_next = in_data;
              w_idx_next = r_cnt;
            end
            // Counter parks at the last index in DONE; it clears on handshake.
            if (r_cnt == LAST_IDX) begin
              w_state_next = DONE;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_next = ACCUM;
            w_cnt_next   = '0;
          end
        end
        default: begin
          w_state_next = ACCUM;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_min   <= 16'h0000;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_min   <= w_min_next;
      r_idx   <= w_idx_next;
    end
  end

endmodule

// File: tb/tb_bf16_stream_argmin.sv
// Self-checking bench for bf16_stream_argmin: vector table plus hand-written
// clear/reset/backpressure sequences, with a queue-based result scoreboard.
module tb_bf16_stream_argmin;

  localparam int N = 10;

  typedef logic [15:0] elems_t [N];
  typedef struct {
    elems_t      data;
    logic [15:0] exp_min;
    logic [3:0]  exp_idx;
  } vec_t;
  typedef struct packed {
    logic [15:0] m;
    logic [3:0]  i;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_min;
  logic [3:0]  out_idx;
  logic        ready_force, ready_rand_en, rand_bit;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  vec_t tbl[10];

  assign out_ready = ready_force | (ready_rand_en & rand_bit);

  bf16_stream_argmin #(.N_ELEM(N), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ordering: signed magnitude as an integer, NaN above everything.
  function automatic int okey(input logic [15:0] v);
    int m;
    if (v[14:7] == 8'hFF && v[6:0] != 7'd0) return 32'h7FFF_FFFF;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic res_t model(input elems_t d);
    int best = 0;
    for (int k = 1; k < N; k++)
      if (okey(d[k]) < okey(d[best])) best = k;
    return '{m: d[best], i: 4'(best)};
  endfunction

  function automatic logic [15:0] rand_elem();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[15], 8'hFF, 7'h41};
      1: return {r[15], 8'h00, r[6:0]};
      2: return {r[15], 15'h7F80};
      3: return {r[15], 15'h0000};
      default: return r[15:0];
    endcase
  endfunction

  task automatic drive_beat(input logic [15:0] d, input bit gaps);
    int g = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input elems_t d, input logic [15:0] em, input logic [3:0] ei,
                             input bit gaps);
    exp_q.push_back('{m: em, i: ei});
    for (int k = 0; k < N; k++) drive_beat(d[k], gaps);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    ready_force = 1'b1; ready_rand_en = 1'b0; rand_bit = 1'b0;

    tbl[0] = '{'{16'h3F80,16'h4000,16'hBF80,16'h4040,16'hC000,16'h3F00,16'h0000,16'hC000,16'h4080,16'h3F80}, 16'hC000, 4'd4};
    tbl[1] = '{'{16'h8000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000}, 16'h8000, 4'd0};
    tbl[2] = '{'{16'h7FC0,16'h7F80,16'h7F80,16'h7F80,16'h7F80,16'h7F80,16'h7F80,16'h7F80,16'h7F80,16'h7F80}, 16'h7F80, 4'd1};
    tbl[3] = '{'{16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1,16'h7FC1}, 16'h7FC1, 4'd0};
    tbl[4] = '{'{16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'h3F80,16'hFF80}, 16'hFF80, 4'd9};
    tbl[5] = '{'{16'h0005,16'h0003,16'h0001,16'h8002,16'h8001,16'h0000,16'h8000,16'h0004,16'h0002,16'h0006}, 16'h8002, 4'd3};
    tbl[6] = '{'{16'h7F80,16'hFFC0,16'h7F80,16'hFF81,16'h7F80,16'h4000,16'h7F80,16'h7F80,16'h7F80,16'h7F80}, 16'h4000, 4'd5};
    tbl[7] = '{'{16'hFF80,16'h0000,16'h3F80,16'hC000,16'h7F80,16'hFF80,16'h8000,16'h4000,16'h0001,16'h8001}, 16'hFF80, 4'd0};
    tbl[8] = '{'{16'hBF80,16'hC000,16'hC040,16'hC080,16'hC0A0,16'hC0C0,16'hC0E0,16'hC100,16'hC110,16'hC120}, 16'hC120, 4'd9};
    tbl[9] = '{'{16'h0000,16'h8000,16'h0000,16'h8000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000}, 16'h0000, 4'd0};

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_min", 32'(out_min), 32'h0);
    chk("rst_out_idx", 32'(out_idx), 32'h0);

    fork
      forever begin
        @(posedge clk); #1;
        rand_bit = 1'($urandom_range(0, 1));
      end
      begin : monitor
        logic        p_valid = 1'b0, p_skip = 1'b1;
        logic [15:0] p_min = '0;
        logic [3:0]  p_idx = '0;
        res_t        e;
        forever begin
          @(negedge clk);
          if (!reset) begin
            chk("ready_vs_valid", 32'(in_ready), 32'(!out_valid));
            if (p_valid && !p_skip) begin
              chk("hold_out_valid", 32'(out_valid), 32'd1);
              chk("hold_out_min", 32'(out_min), 32'(p_min));
              chk("hold_out_idx", 32'(out_idx), 32'(p_idx));
            end
            if (out_valid && out_ready && !clear) begin
              if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_result: got min=%h idx=%0d expected none", out_min, out_idx);
              end else begin
                e = exp_q.pop_front();
                $display("[TB] result min=%h idx=%0d (exp %h/%0d)", out_min, out_idx, e.m, e.i);
                chk("result_min", 32'(out_min), 32'(e.m));
                chk("result_idx", 32'(out_idx), 32'(e.i));
              end
            end
          end
          p_valid = out_valid;
          p_min   = out_min;
          p_idx   = out_idx;
          p_skip  = reset || clear || (out_valid && out_ready);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 10; t++) begin
      send_vector(tbl[t].data, tbl[t].exp_min, tbl[t].exp_idx, 1'b0);
      wait_drain();
    end

    // Backpressure: result held while out_ready is low and in_valid is high.
    ready_force = 1'b0;
    send_vector(tbl[0].data, tbl[0].exp_min, tbl[0].exp_idx, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hFF80;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_min", 32'(out_min), 32'hC000);
    end
    ready_force = 1'b1;
    in_valid    = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear mid-vector, with a simultaneous beat that must be ignored.
    for (int k = 0; k < 6; k++) drive_beat(rand_elem(), 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'hFF80;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    begin
      elems_t d = '{16'h4000,16'h3F80,16'hBF80,16'h4040,16'h3F00,16'h0000,16'hBF80,16'h4080,16'h7F80,16'h3F80};
      send_vector(d, 16'hBF80, 4'd2, 1'b0);
      wait_drain();
    end

    // Clear coinciding with an output handshake: result dropped, no repeat.
    ready_force = 1'b0;
    send_vector(tbl[1].data, tbl[1].exp_min, tbl[1].exp_idx, 1'b0);
    clear = 1'b1; ready_force = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_hs_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      chk("clr_hs_no_dup", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-vector, then random-gap traffic.
    ready_force = 1'b0; ready_rand_en = 1'b1;
    drive_beat(16'h3F80, 1'b1); drive_beat(16'hBF80, 1'b1);
    drive_beat(16'h4000, 1'b1); drive_beat(16'hC000, 1'b1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_min", 32'(out_min), 32'h0);
    chk("async_rst_out_idx", 32'(out_idx), 32'h0);
    @(posedge clk); #4;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int v = 0; v < 5; v++) begin
      elems_t d;
      res_t   r;
      for (int k = 0; k < N; k++) d[k] = rand_elem();
      r = model(d);
      send_vector(d, r.m, r.i, 1'b1);
      wait_drain();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
